// File: rtl/uart_tx_ctrl.sv
// UART transmit controller with per-frame baud divisor.
// Frames: start, LSB-first data, optional even parity, stop bit(s).
module uart_tx_ctrl #(
    parameter int          DATA_BITS = 8,
    parameter int          STOP_BITS = 1,
    parameter int          PARITY_EN = 0,
    parameter logic [15:0] DEF_DIV   = 16'd5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_div,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        tx_out,
    output logic        busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] DMASK     = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop_q, stop_d;
    logic        out_q, out_d;
    logic        cnt_last;

    assign cnt_last = (cnt_q == div_q - 16'd1);
    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_out   = out_q;
    assign tx_done  = (state_q == STOP) && cnt_last && (stop_q == STOP_LAST);

    // State, counters and the registered serial line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            out_q   <= out_d;
        end
    end

    // Next-state logic; the line value for the next bit is set at each boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                out_d = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    div_d   = (baud_div >= 16'd2) ? baud_div : DEF_DIV;
                    par_d   = ^(tx_data & DMASK);
                    cnt_d   = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    out_d   = 1'b0;
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    out_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            out_d   = par_q;
                        end else begin
                            state_d = STOP;
                            stop_d  = 1'b0;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        out_d = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    stop_d  = 1'b0;
                    out_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                out_d = 1'b1;
                if (cnt_last) begin
                    cnt_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances cover
// 8N1 (default divisor 6) and 8E2 framing.
module tb_uart_tx_ctrl;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
        bit         abort;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] baud_div [2];
    logic        tx_valid [2];
    logic [7:0]  tx_data  [2];
    logic        tx_ready [2];
    logic        tx_out   [2];
    logic        busy     [2];
    logic        tx_done  [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    uart_tx_ctrl #(
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .DEF_DIV(16'd6)
    ) u_dut0 (
        .clk(clk), .reset(reset), .baud_div(baud_div[0]),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]),
        .busy(busy[0]), .tx_done(tx_done[0])
    );

    uart_tx_ctrl #(
        .DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(1), .DEF_DIV(16'd6)
    ) u_dut1 (
        .clk(clk), .reset(reset), .baud_div(baud_div[1]),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]),
        .busy(busy[1]), .tx_done(tx_done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic push(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor: one per instance, pops an expectation at each frame start.
    task automatic monitor(input int id);
        exp_t e;
        logic bits [12];
        logic [7:0] got;
        int nb, p, errs, last_done;
        bit aborted, empty;
        last_done = -100;
        forever begin
            @(negedge clk);
            if (!reset || !busy[id]) continue;
            empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
            chk($sformatf("frame_expected[%0d]", id), {31'd0, !empty}, 32'd1);
            if (empty) begin
                while (busy[id] && reset) @(negedge clk);
                continue;
            end
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            if (e.b2b)
                chk($sformatf("b2b_gap[%0d]", id), cyc - last_done, 32'd2);
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1 + i] = e.data[i];
            p = 9;
            if (id == 1) begin
                bits[p] = ^e.data;
                p++;
            end
            for (int s = 0; s < ((id == 1) ? 2 : 1); s++) bits[p + s] = 1'b1;
            nb = p + ((id == 1) ? 2 : 1);
            errs = 0;
            aborted = 0;
            got = '0;
            for (int k = 0; k < nb && !aborted; k++) begin
                for (int c = 0; c < e.div; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    if (!reset) begin
                        aborted = 1;
                        break;
                    end
                    if (tx_out[id] !== bits[k] || busy[id] !== 1'b1 ||
                        tx_ready[id] !== 1'b0 ||
                        tx_done[id] !== (k == nb - 1 && c == e.div - 1))
                        errs++;
                    if (c == e.div / 2 && k >= 1 && k <= 8)
                        got[k - 1] = tx_out[id];
                    if (k == nb - 1 && c == e.div - 1) last_done = cyc;
                end
            end
            chk($sformatf("abort[%0d]", id), {31'd0, aborted}, {31'd0, e.abort});
            if (!aborted) begin
                chk($sformatf("wave_errs[%0d] %02h", id, e.data), errs, 32'd0);
                chk($sformatf("data[%0d]", id), {24'd0, got}, {24'd0, e.data});
                @(negedge clk);
                chk($sformatf("idle_after[%0d]", id),
                    {28'd0, tx_out[id], busy[id], tx_ready[id], tx_done[id]},
                    32'b1010);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic send(input int id, input logic [7:0] d, input logic [15:0] bd,
                        input int ediv, input bit b2b, input bit ab, input bit hold);
        exp_t e;
        int n;
        @(negedge clk);
        tx_valid[id] = 1'b1;
        tx_data[id]  = d;
        baud_div[id] = bd;
        n = 0;
        while (!tx_ready[id] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready[id]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            tx_valid[id] = 1'b0;
            return;
        end
        e.data  = d;
        e.div   = ediv;
        e.b2b   = b2b;
        e.abort = ab;
        push(id, e);
        @(posedge clk);
        #1;
        if (!hold) tx_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n;
        repeat (2) @(negedge clk);
        n = 0;
        while (busy[id] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy[id]) chk("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            baud_div[i] = 16'd4;
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_tx_out", {31'd0, tx_out[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready[0]}, 32'd1);
        chk("rst_done", {31'd0, tx_done[0]}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 8N1 frame, 4 clocks per bit.
        send(0, 8'hA5, 16'd4, 4, 0, 0, 0);
        wait_idle(0);

        // Back-to-back with tx_valid held.
        send(0, 8'h00, 16'd4, 4, 0, 0, 1);
        send(0, 8'hFF, 16'd4, 4, 1, 0, 0);
        wait_idle(0);

        // Divisor clamp to DEF_DIV=6; mid-frame change has no effect.
        send(0, 8'h5A, 16'd0, 6, 0, 0, 0);
        repeat (20) @(negedge clk);
        baud_div[0] = 16'd10;
        wait_idle(0);
        send(0, 8'h96, 16'd1, 6, 0, 0, 0);
        wait_idle(0);

        // Request during DATA is ignored.
        send(0, 8'h81, 16'd4, 4, 0, 0, 0);
        repeat (10) @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h3C;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        wait_idle(0);
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of DATA.
        send(0, 8'hC3, 16'd4, 4, 0, 1, 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_tx_out", {31'd0, tx_out[0]}, 32'd1);
        chk("abort_busy", {31'd0, busy[0]}, 32'd0);
        chk("abort_ready", {31'd0, tx_ready[0]}, 32'd1);
        chk("abort_done", {31'd0, tx_done[0]}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send(0, 8'h55, 16'd4, 4, 0, 0, 0);
        wait_idle(0);

        // Even parity, two stop bits.
        send(1, 8'h07, 16'd2, 2, 0, 0, 0);
        wait_idle(1);
        send(1, 8'h03, 16'd3, 3, 0, 0, 0);
        wait_idle(1);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
